// File: rtl/delay_pkg.sv
// Shared definitions for the programmable request delay block.
//   MODE_2PH / MODE_PULSE : event encoding selectors for the MODE parameter.
//   CNT_W_DEF            : default delay-count width.
//   ch_state_e           : per-channel occupancy (idle, one in flight, one queued).
package delay_pkg;

  localparam int MODE_2PH   = 0;
  localparam int MODE_PULSE = 1;
  localparam int CNT_W_DEF  = 4;

  typedef enum logic [1:0] {
    CH_IDLE      = 2'd0,
    CH_BUSY      = 2'd1,
    CH_BUSY_PEND = 2'd2
  } ch_state_e;

endpackage

// File: rtl/delay_prog_ch.sv
// One delay channel: edge detect, countdown, single-entry queue, sticky overflow.
//   clk, rst : clock, synchronous active-high reset
//   in_r     : request input (level per event in 2-phase, rising edge in pulse mode)
//   dly      : current shadow delay value for this channel
//   out_r    : registered delayed request output
//   busy     : an event is counting down
//   pend     : one event is queued behind the in-flight one
//   ovf      : sticky, an event was dropped
module delay_prog_ch
  import delay_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int MODE  = MODE_2PH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_r,
  input  logic [CNT_W-1:0] dly,
  output logic             out_r,
  output logic             busy,
  output logic             pend,
  output logic             ovf
);

  // Counter is one bit wider than the delay so a reload can hold D+1:
  // the queued event spends one extra edge in the reload before counting.
  localparam logic [CNT_W:0] ONE = {{CNT_W{1'b0}}, 1'b1};

  ch_state_e      state_q, state_d;
  logic [CNT_W:0] cnt_q, cnt_d;
  logic           in_q;
  logic           out_q, out_d;
  logic           ovf_q, ovf_d;
  logic           ev, fire;
  logic [CNT_W:0] dly_ext;

  assign dly_ext = {1'b0, dly};

  always_comb begin
    ev      = (MODE == MODE_PULSE) ? (in_r & ~in_q) : (in_r ^ in_q);
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    fire    = 1'b0;
    case (state_q)
      CH_IDLE: begin
        if (ev) begin
          if (dly == '0) begin
            fire = 1'b1;                 // zero delay: passes straight through
          end else begin
            cnt_d   = dly_ext;
            state_d = CH_BUSY;
          end
        end
      end
      CH_BUSY: begin
        if (cnt_q == ONE) begin
          fire = 1'b1;
          if (ev) begin
            cnt_d = dly_ext + ONE;       // event on firing edge is treated as queued
          end else begin
            cnt_d   = '0;
            state_d = CH_IDLE;
          end
        end else begin
          cnt_d = cnt_q - ONE;
          if (ev) state_d = CH_BUSY_PEND;
        end
      end
      CH_BUSY_PEND: begin
        if (ev) ovf_d = 1'b1;            // no room: event dropped
        if (cnt_q == ONE) begin
          fire    = 1'b1;
          cnt_d   = dly_ext + ONE;
          state_d = CH_BUSY;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: begin
        state_d = CH_IDLE;
        cnt_d   = '0;
      end
    endcase
    out_d = (MODE == MODE_PULSE) ? fire : (out_q ^ fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CH_IDLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      ovf_q   <= 1'b0;
      in_q    <= in_r;                   // level held through reset is not an event
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      ovf_q   <= ovf_d;
      in_q    <= in_r;
    end
  end

  assign out_r = out_q;
  assign busy  = (state_q != CH_IDLE);
  assign pend  = (state_q == CH_BUSY_PEND);
  assign ovf   = ovf_q;

endmodule

// File: rtl/delay_prog_nch.sv
// CH-channel programmable request delay with shared shadow delay registers.
//   clk, rst : clock, synchronous active-high reset
//   inR      : per-channel request inputs
//   outR     : per-channel delayed requests (registered)
//   cfg_dly  : packed per-channel delays, channel i at [i*CNT_W +: CNT_W]
//   cfg_we   : load cfg_dly into the shadow registers
//   busy, pend, ovf : per-channel status
module delay_prog_nch
  import delay_pkg::*;
#(
  parameter int CH    = 4,
  parameter int CNT_W = CNT_W_DEF,
  parameter int MODE  = MODE_2PH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CH-1:0]       inR,
  output logic [CH-1:0]       outR,
  input  logic [CH*CNT_W-1:0] cfg_dly,
  input  logic                cfg_we,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       pend,
  output logic [CH-1:0]       ovf
);

  // Channels read the registered shadow, so a load on the cfg_we edge
  // still sees the previous value.
  logic [CH-1:0][CNT_W-1:0] shadow_q, shadow_d;

  always_comb begin
    shadow_d = shadow_q;
    if (cfg_we) shadow_d = cfg_dly;
  end

  always_ff @(posedge clk) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  for (genvar g = 0; g < CH; g++) begin : g_ch
    delay_prog_ch #(
      .CNT_W(CNT_W),
      .MODE (MODE)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .in_r (inR[g]),
      .dly  (shadow_q[g]),
      .out_r(outR[g]),
      .busy (busy[g]),
      .pend (pend[g]),
      .ovf  (ovf[g])
    );
  end

endmodule

// File: tb/tb_delay_prog_nch.sv
// Directed bench: one two-phase instance and one pulse-mode instance.
module tb_delay_prog_nch;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in0, in1;
  logic [15:0] cfg_dly;
  logic        cfg_we;
  logic [3:0]  out0, busy0, pend0, ovf0;
  logic [3:0]  out1, busy1, pend1, ovf1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  delay_prog_nch #(.CH(4), .CNT_W(4), .MODE(0)) dut0 (
    .clk(clk), .rst(rst), .inR(in0), .outR(out0), .cfg_dly(cfg_dly),
    .cfg_we(cfg_we), .busy(busy0), .pend(pend0), .ovf(ovf0)
  );

  delay_prog_nch #(.CH(4), .CNT_W(4), .MODE(1)) dut1 (
    .clk(clk), .rst(rst), .inR(in1), .outR(out1), .cfg_dly(cfg_dly),
    .cfg_we(cfg_we), .busy(busy1), .pend(pend1), .ovf(ovf1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One active edge, then settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [3:0] a, input logic [3:0] b);
    rst = 1'b1; in0 = a; in1 = b;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic load_cfg(input logic [15:0] v);
    cfg_dly = v; cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in0 = '0; in1 = '0; cfg_dly = '0; cfg_we = 1'b0;

    // Reset with inputs held high: nothing is an event
    do_reset(4'b1111, 4'b1111);
    chk("rst_out0", 32'(out0), 0);
    chk("rst_busy0", 32'(busy0), 0);
    chk("rst_pend0", 32'(pend0), 0);
    chk("rst_ovf0", 32'(ovf0), 0);
    chk("rst_out1", 32'(out1), 0);
    for (int j = 0; j < 20; j++) begin
      tick();
      chk("idle_out0", 32'(out0), 0);
      chk("idle_busy0", 32'(busy0), 0);
      chk("idle_out1", 32'(out1), 0);
    end

    // ch0 D=5 single event
    do_reset(4'b0000, 4'b0000);
    load_cfg(16'h0635);
    in0 = 4'b0001;
    tick();                                   // edge k
    chk("c0_busy_k", 32'(busy0[0]), 1);
    chk("c0_out_k", 32'(out0[0]), 0);
    for (int j = 1; j <= 4; j++) begin
      tick();
      chk("c0_busy_run", 32'(busy0[0]), 1);
      chk("c0_out_run", 32'(out0[0]), 0);
    end
    tick();                                   // k+5
    chk("c0_out_fire", 32'(out0[0]), 1);
    chk("c0_busy_done", 32'(busy0[0]), 0);

    // ch1 D=3 two events one cycle apart: fire at k+3 and k+7
    do_reset(4'b0000, 4'b0000);
    load_cfg(16'h0635);
    in0 = 4'b0010; tick();                    // k
    in0 = 4'b0000; tick();                    // k+1
    chk("c1_pend", 32'(pend0[1]), 1);
    tick();                                   // k+2
    chk("c1_out_k2", 32'(out0[1]), 0);
    tick();                                   // k+3
    chk("c1_out_k3", 32'(out0[1]), 1);
    chk("c1_pend_k3", 32'(pend0[1]), 0);
    chk("c1_busy_k3", 32'(busy0[1]), 1);
    for (int j = 4; j <= 6; j++) begin
      tick();
      chk("c1_out_hold", 32'(out0[1]), 1);
    end
    tick();                                   // k+7
    chk("c1_out_k7", 32'(out0[1]), 0);
    chk("c1_out_eq_in", 32'(out0[1]), 32'(in0[1]));
    chk("c1_busy_end", 32'(busy0[1]), 0);
    chk("c1_ovf", 32'(ovf0[1]), 0);

    // ch2 D=6 three events in consecutive edges: overflow, two transitions
    do_reset(4'b0000, 4'b0000);
    load_cfg(16'h0635);
    in0 = 4'b0100; tick();                    // k
    in0 = 4'b0000; tick();                    // k+1
    chk("c2_ovf_pre", 32'(ovf0[2]), 0);
    in0 = 4'b0100; tick();                    // k+2
    chk("c2_ovf_set", 32'(ovf0[2]), 1);
    for (int j = 3; j <= 25; j++) begin
      tick();
      chk("c2_out", 32'(out0[2]), (j >= 6 && j < 13) ? 1 : 0);
    end
    chk("c2_ovf_sticky", 32'(ovf0[2]), 1);
    chk("c2_busy_end", 32'(busy0[2]), 0);
    do_reset(4'b0100, 4'b0000);
    chk("c2_ovf_rst", 32'(ovf0[2]), 0);

    // Pulse mode ch3 D=0: single one-cycle pulse on the detecting edge
    do_reset(4'b0000, 4'b0000);
    load_cfg(16'h0635);
    in1 = 4'b1000; tick();                    // k
    chk("p3_pulse", 32'(out1), 32'h8);
    chk("p3_busy", 32'(busy1[3]), 0);
    for (int j = 0; j < 5; j++) begin
      tick();
      chk("p3_quiet", 32'(out1), 0);
    end
    chk("p3_2ph_quiet", 32'(out0), 0);

    // ch0 D=10 in flight, shadow rewritten to 2 mid-count; then reset mid-count
    do_reset(4'b0000, 4'b0000);
    load_cfg(16'h063A);
    in0 = 4'b0011; tick();                    // k (ch1 D=3 also fires)
    for (int j = 1; j <= 4; j++) tick();      // k+4
    cfg_dly = 16'h0632; cfg_we = 1'b1;
    tick();                                   // k+5
    cfg_we = 1'b0;
    for (int j = 6; j <= 9; j++) begin
      tick();
      chk("c0_old_dly", 32'(out0[0]), 0);
    end
    tick();                                   // k+10
    chk("c0_fire10", 32'(out0), 32'h3);
    chk("c0_busy10", 32'(busy0[0]), 0);
    in0 = 4'b0010; tick();                    // m
    chk("c0_new_busy", 32'(busy0[0]), 1);
    tick();                                   // m+1
    chk("c0_new_m1", 32'(out0[0]), 1);
    tick();                                   // m+2
    chk("c0_new_m2", 32'(out0[0]), 0);
    in0 = 4'b0011; tick();                    // p
    in0 = 4'b0010; tick();                    // p+1
    chk("c0_pend_mid", 32'(pend0[0]), 1);
    rst = 1'b1; tick();
    chk("mid_rst_out", 32'(out0), 0);
    chk("mid_rst_busy", 32'(busy0), 0);
    chk("mid_rst_pend", 32'(pend0), 0);
    rst = 1'b0;
    tick(); tick(); tick();
    chk("post_rst_out", 32'(out0), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/delay_prog_nch.md
Name: delay_prog_nch

Overview:
- Clocked, parametrised successor to the fixed-length request delay chains in the control/delay library.
- Holds CH independent request channels. Each channel forwards a request event from inR to outR after a runtime-programmable number of clock cycles.
- Each channel can queue one event while another is in flight, and flags overflow when it cannot.
- Sits between clocked control logic and handshake/request paths that need tunable matched delays without re-synthesising delay cells.

Parameters:
- CH, 4, number of independent channels.
- CNT_W, 4, width of the per-channel delay count; maximum delay is 2^CNT_W-1 cycles.
- MODE, 0, event encoding. 0 = two-phase: every level change of inR is one event, and outR toggles per event. 1 = pulse: only a rising edge of inR is an event, and outR emits a one-cycle high pulse.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- inR  input  CH  per-channel request inputs; synchronous to clk.
- outR  output  CH  per-channel delayed request outputs; registered.
- cfg_dly  input  CH*CNT_W  per-channel delay values; channel i uses bits [i*CNT_W +: CNT_W].
- cfg_we  input  1  latches cfg_dly into the shadow delay registers.
- busy  output  CH  channel i has an event counting down.
- pend  output  CH  channel i has one queued event.
- ovf  output  CH  sticky overflow flag per channel; cleared only by rst.

Behaviour:
- Reset (rst high at an edge):
  - outR, busy, pend, ovf, counters and shadow delays all go to 0.
  - in_q <= inR, so an input level present when rst deasserts is never taken as an event.
- Event detection:
  - MODE 0: event when inR[i] != in_q[i].
  - MODE 1: event when inR[i] & ~in_q[i].
  - in_q <= inR on every non-reset edge.
- Delay D is the shadow value at load time:
  - An event detected at edge k while the channel is idle loads cnt <= D and sets busy.
  - outR fires at edge k+D. With D=0 it fires at edge k and busy never asserts.
  - In MODE 1 the outR pulse lasts exactly one cycle.
- Countdown: while busy, cnt decrements each edge. At the edge where cnt==1 the output fires, busy clears and cnt reaches 0.
- Queued event:
  - An event arriving while busy with pend clear sets pend.
  - On the firing edge, if pend is set: clear pend, reload cnt <= current shadow D, and keep busy set. The queued event fires D+1 edges after the first output (one reload cycle).
  - A queued event with D=0 fires on the edge after the first output.
- Event on the firing edge itself: it becomes the queued event if pend is clear. If pend is already set, it is an overflow.
- Overflow:
  - An event while busy with pend set sets ovf[i], and the event is dropped.
  - In MODE 0 the outR parity is then corrupt; the system must reset.
- Configuration:
  - cfg_we at edge k updates the shadow at edge k.
  - A load in the same edge uses the old shadow.
  - In-flight counts are unaffected; the next load uses the new value.
- Independence: channels never interact. Simultaneous events on all channels are legal.
- Reset mid-operation: pending and in-flight events are discarded, and outR returns to 0 immediately.

Decomposition:
- Package delay_pkg holds:
  - MODE_2PH=0 and MODE_PULSE=1 constants;
  - the default CNT_W;
  - a typedef for the per-channel state: idle/busy/busy_pend.
- Sub-module delay_prog_ch implements one channel: edge detect, counter, pend/ovf logic, with MODE and CNT_W parameters.
- The top-level generates CH instances, slices cfg_dly, and holds the shared cfg_we shadow-register write.

Test Plan:
- Reset release with inR=4'b1111 (MODE 0) -> no events; outR stays 0 and busy stays 0 for 20 cycles.
- cfg_dly ch0=5, cfg_we. Toggle inR[0] so it is detected at edge k -> outR[0] toggles at edge k+5; busy[0] high for edges k..k+4.
- MODE 0, ch1 D=3: two toggles 1 cycle apart -> pend[1] set. Outputs toggle at k+3 and k+7; final outR[1] equals inR[1]; ovf[1]=0.
- ch2 D=6: three events within 2 cycles -> ovf[2]=1 after the third event; only two outR transitions occur; ovf stays 1 until rst.
- MODE 1, ch3 D=0: rising edge at edge k -> single one-cycle outR[3] pulse at edge k. Holding inR high produces no further pulses.
- ch0 D=10 in flight, cfg_we with D=2 at mid-count -> the in-flight event still fires at 10. The next event fires after 2. Asserting rst mid-count clears outR, busy and pend next edge.
